led_pattern_gen: RTL and testbench

//  Downstream consumer of the LED prescaler chain and the 8-bit LED control parameter.

---
 rtl/led_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: decodes an 8-bit control word into off/on/blink/breathe
// drive patterns. Parameter changes are applied only on PWM frame boundaries.
module led_pattern_gen #(
  parameter int PWM_PRESC   = 4,
  parameter int BREATHE_INC = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step_tick,
  input  logic       para_load,
  input  logic [7:0] led_para,
  output logic       para_ack,
  output logic [3:0] led
);

  localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESC - 1);
  localparam logic [8:0]    INC9       = 9'(BREATHE_INC);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  // Handshake: a para_load arms a pending update that is applied at the next
  // frame boundary; para_ack pulses one cycle after that boundary.
  typedef enum logic {HS_IDLE = 1'b0, HS_PENDING = 1'b1} hs_state_t;

  hs_state_t     state_q, state_d;
  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic          adv, fb, apply;
  logic [7:0]    shadow;
  logic [1:0]    mode, rate;
  logic [3:0]    mask;
  logic [1:0]    step_cnt;
  logic          phase, dir_up;
  logic [7:0]    duty;
  logic [7:0]    duty_d;
  logic          dir_d;
  logic [8:0]    duty_up, duty_dn;
  logic [3:0]    led_d;

  assign adv = (presc == PRESC_LAST);
  assign fb  = adv && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (adv) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= HS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HS_IDLE:    if (para_load) state_d = HS_PENDING;
      HS_PENDING: if (fb && !para_load) state_d = HS_IDLE;
      default:    state_d = HS_IDLE;
    endcase
  end

  always_comb begin
    apply = (state_q == HS_PENDING) && fb;
  end

  // shadow is read before being overwritten, so a load on the boundary cycle
  // applies the older value now and the new one at the following boundary.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow   <= '0;
      mode     <= MODE_OFF;
      mask     <= '0;
      rate     <= '0;
      para_ack <= 1'b0;
    end else begin
      para_ack <= apply;
      if (para_load) shadow <= led_para;
      if (apply) begin
        mode <= shadow[1:0];
        rate <= shadow[3:2];
        mask <= shadow[7:4];
      end
    end
  end

  // Saturating breathe arithmetic; 9 bits so overflow/borrow is visible.
  always_comb begin
    duty_up = {1'b0, duty} + INC9;
    duty_dn = {1'b0, duty} - INC9;
    duty_d  = duty;
    dir_d   = dir_up;
    if (dir_up) begin
      if (duty_up >= 9'd255) begin
        duty_d = 8'hFF;
        dir_d  = 1'b0;
      end else begin
        duty_d = duty_up[7:0];
      end
    end else begin
      if (duty_dn[8] || (duty_dn == 9'd0)) begin
        duty_d = 8'h00;
        dir_d  = 1'b1;
      end else begin
        duty_d = duty_dn[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_cnt <= '0;
      phase    <= 1'b0;
      duty     <= '0;
      dir_up   <= 1'b1;
    end else if (apply) begin
      step_cnt <= '0;
      phase    <= 1'b1;
      duty     <= '0;
      dir_up   <= 1'b1;
    end else if (step_tick) begin
      if (step_cnt == rate) begin
        step_cnt <= '0;
        phase    <= ~phase;
        duty     <= duty_d;
        dir_up   <= dir_d;
      end else begin
        step_cnt <= step_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    led_d = 4'h0;
    case (mode)
      MODE_OFF:     led_d = 4'h0;
      MODE_ON:      led_d = mask;
      MODE_BLINK:   led_d = mask & {4{phase}};
      MODE_BREATHE: led_d = mask & {4{pwm_cnt < duty}};
      default:      led_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) led <= 4'h0;
    else          led <= led_d;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random traffic, compared
// cycle by cycle against an arithmetic reference model of the pattern rules.
module tb_led_pattern_gen;

  localparam int P     = 4;
  localparam int INC   = 8;
  localparam int FRAME = 256 * P;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       step_tick;
  logic       para_load;
  logic [7:0] led_para;
  logic       para_ack;
  logic [3:0] led;

  led_pattern_gen #(.PWM_PRESC(P), .BREATHE_INC(INC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .step_tick (step_tick),
    .para_load (para_load),
    .led_para  (led_para),
    .para_ack  (para_ack),
    .led       (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  // Reference model state: time since reset drives the PWM position directly.
  int         cyc;
  logic [1:0] m_mode, m_rate;
  logic [3:0] m_mask;
  logic [7:0] m_shadow;
  bit         m_pend;
  int         m_scnt;
  bit         m_phase;
  int         m_duty;
  bit         m_up;
  logic [3:0] m_led;
  bit         m_ack;

  function automatic bit chance(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  task automatic model_update();
    int pwm;
    bit fb, apply;
    if (!reset_n) begin
      cyc = 0; m_mode = 0; m_mask = 0; m_rate = 0; m_shadow = 0; m_pend = 0;
      m_scnt = 0; m_phase = 0; m_duty = 0; m_up = 1; m_led = 0; m_ack = 0;
    end else begin
      pwm = (cyc / P) % 256;
      fb  = (cyc % FRAME) == FRAME - 1;
      case (m_mode)
        2'd0: m_led = 4'h0;
        2'd1: m_led = m_mask;
        2'd2: m_led = m_phase ? m_mask : 4'h0;
        default: m_led = (pwm < m_duty) ? m_mask : 4'h0;
      endcase
      apply = m_pend && fb;
      m_ack = apply;
      if (apply) begin
        m_mode = m_shadow[1:0]; m_rate = m_shadow[3:2]; m_mask = m_shadow[7:4];
        m_scnt = 0; m_phase = 1; m_duty = 0; m_up = 1;
      end else if (step_tick) begin
        if (m_scnt == int'(m_rate)) begin
          m_scnt  = 0;
          m_phase = !m_phase;
          if (m_up) begin
            m_duty = (m_duty + INC > 255) ? 255 : m_duty + INC;
            if (m_duty == 255) m_up = 0;
          end else begin
            m_duty = (m_duty - INC < 0) ? 0 : m_duty - INC;
            if (m_duty == 0) m_up = 1;
          end
        end else begin
          m_scnt = (m_scnt + 1) % 4;
        end
      end
      if (para_load) begin
        m_shadow = led_para;
        m_pend   = 1;
      end else if (apply) begin
        m_pend = 0;
      end
      cyc++;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input bit st, input bit pl, input logic [7:0] para);
    step_tick = st;
    para_load = pl;
    led_para  = para;
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (para_ack === 1'b1) ack_seen++;
    checks++;
    assert (led === m_led) else begin
      errors++;
      $error("FAIL led: observed %h expected %h at cycle %0d", led, m_led, cyc);
    end
    checks++;
    assert (para_ack === m_ack) else begin
      errors++;
      $error("FAIL para_ack: observed %b expected %b at cycle %0d", para_ack, m_ack, cyc);
    end
  endtask

  task automatic run(input int n, input int st_odds);
    for (int i = 0; i < n; i++) cycle(chance(st_odds), 1'b0, 8'h00);
  endtask

  task automatic run_to_pwm(input int target);
    for (int i = 0; i < FRAME && ((cyc / P) % 256) != target; i++) cycle(chance(8), 1'b0, 8'h00);
  endtask

  task automatic run_to_fb_cycle();
    for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) cycle(chance(8), 1'b0, 8'h00);
  endtask

  initial begin
    bit reached;
    reset_n   = 1'b0;
    step_tick = 1'b0;
    para_load = 1'b0;
    led_para  = 8'h00;
    @(negedge clk);

    // Reset with para_load toggling: nothing may leak through.
    for (int i = 0; i < 8; i++) cycle(chance(2), chance(2), 8'($urandom));
    reset_n = 1'b1;
    run(20, 8);

    // Constant-on load mid-frame.
    run_to_pwm(10);
    cycle(1'b0, 1'b1, 8'hF1);
    run(FRAME + 16, 8);

    // Blink, rate 2, one step_tick every 20 clk.
    cycle(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 4 * FRAME; i++) cycle((i % 20) == 0, 1'b0, 8'h00);

    // Breathe, rate 0, then reset once duty reaches 128.
    cycle(1'b0, 1'b1, 8'h33);
    run(2 * FRAME, 16);
    reached = 0;
    for (int i = 0; i < 8 * FRAME && !reached; i++) begin
      if (m_mode == 2'd3 && m_duty == 128) reached = 1;
      else cycle(chance(16), 1'b0, 8'h00);
    end
    checks++;
    assert (reached) else begin
      errors++;
      $error("FAIL breathe_reach: observed duty %0d expected 128", m_duty);
    end
    reset_n = 1'b0;
    cycle(1'b1, 1'b1, 8'hF3);
    reset_n = 1'b1;
    run(FRAME + 8, 8);

    // Two loads before one boundary: only the latest applies, one ack.
    run_to_pwm(20);
    ack_seen = 0;
    cycle(1'b0, 1'b1, 8'h11);
    run(30, 8);
    cycle(1'b0, 1'b1, 8'h21);
    run(FRAME + 8, 8);
    checks++;
    assert (ack_seen == 1) else begin
      errors++;
      $error("FAIL single_ack: observed %0d acks expected 1", ack_seen);
    end

    // Load on the boundary cycle with nothing pending.
    run_to_fb_cycle();
    cycle(1'b0, 1'b1, 8'h32);
    run(FRAME + 8, 4);

    // Load on the boundary with an older value pending.
    run_to_pwm(40);
    cycle(1'b0, 1'b1, 8'hC2);
    run_to_fb_cycle();
    cycle(1'b0, 1'b1, 8'hA3);
    run(2 * FRAME + 8, 4);

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      reset_n = !chance(2000);
      cycle(chance(8), chance(300), 8'($urandom));
    end
    reset_n = 1'b1;
    run(FRAME, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
